// File: rtl/lifo_drain_ctrl.sv
// Drain controller for the 8-deep LIFO stack: pops on request and streams bytes out over valid/ready.
// Optional trailing checksum byte when LIFO_DRAIN_CHECKSUM_EN is defined.
module lifo_drain_ctrl #(
  parameter int DW    = 8,
  parameter int CNT_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  input  logic             empty,
  input  logic [DW-1:0]    stk_data,
  output logic             rn,
  output logic [DW-1:0]    out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             busy,
  output logic [CNT_W-1:0] popped
);

`ifdef LIFO_DRAIN_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, CHECK, POP, CAPT, SEND, CSUM} state_t;
`else
  typedef enum logic [2:0] {IDLE, CHECK, POP, CAPT, SEND} state_t;
`endif

  state_t           state_q;
  logic [CNT_W-1:0] target_q;
  logic [CNT_W-1:0] popped_q;
  logic [DW-1:0]    data_q;
  logic             rn_q;
  logic             valid_q;
  logic             last_q;
  logic             busy_q;
`ifdef LIFO_DRAIN_CHECKSUM_EN
  logic [DW-1:0]    csum_q;
`endif

  logic pop_ok;
  logic last_ahead;

  assign pop_ok     = !empty && ((target_q == '0) || (popped_q < target_q));
  // Evaluated in CAPT, after popped has advanced and the stack has settled,
  // so it predicts exactly what the following CHECK will decide.
  assign last_ahead = ((target_q != '0) && (popped_q == target_q)) || empty;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      target_q <= '0;
      popped_q <= '0;
      data_q   <= '0;
      rn_q     <= 1'b0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      busy_q   <= 1'b0;
`ifdef LIFO_DRAIN_CHECKSUM_EN
      csum_q   <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q  <= CHECK;
            busy_q   <= 1'b1;
            target_q <= count;
            popped_q <= '0;
`ifdef LIFO_DRAIN_CHECKSUM_EN
            csum_q   <= '0;
`endif
          end
        end
        CHECK: begin
          if (pop_ok) begin
            state_q <= POP;
            rn_q    <= 1'b1;
          end else begin
`ifdef LIFO_DRAIN_CHECKSUM_EN
            state_q <= CSUM;
            data_q  <= csum_q;
            valid_q <= 1'b1;
            last_q  <= 1'b1;
`else
            state_q <= IDLE;
            busy_q  <= 1'b0;
`endif
          end
        end
        POP: begin
          state_q  <= CAPT;
          rn_q     <= 1'b0;
          popped_q <= popped_q + 1'b1;
        end
        CAPT: begin
          state_q <= SEND;
          data_q  <= stk_data;
          valid_q <= 1'b1;
`ifdef LIFO_DRAIN_CHECKSUM_EN
          csum_q  <= csum_q + stk_data;
          last_q  <= 1'b0;
`else
          last_q  <= last_ahead;
`endif
        end
        SEND: begin
          if (out_ready) begin
            state_q <= CHECK;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
          end
        end
`ifdef LIFO_DRAIN_CHECKSUM_EN
        CSUM: begin
          if (out_ready) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
          end
        end
`endif
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          rn_q    <= 1'b0;
          valid_q <= 1'b0;
          last_q  <= 1'b0;
        end
      endcase
    end
  end

  assign rn        = rn_q;
  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign out_last  = last_q;
  assign busy      = busy_q;
  assign popped    = popped_q;

endmodule

// File: tb/tb_lifo_drain_ctrl.sv
// Bench for lifo_drain_ctrl: LIFO stack model on the falling edge, queue-based
// expected byte stream, directed table plus randomized drains.
module tb_lifo_drain_ctrl;
  localparam int DW    = 8;
  localparam int CNT_W = 4;
`ifdef LIFO_DRAIN_CHECKSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif

  logic             clock = 1'b0;
  logic             reset;
  logic             start;
  logic [CNT_W-1:0] count;
  logic             empty;
  logic [DW-1:0]    stk_data;
  logic             rn;
  logic [DW-1:0]    out_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;
  logic             busy;
  logic [CNT_W-1:0] popped;

  lifo_drain_ctrl #(.DW(DW), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .start(start), .count(count), .empty(empty),
    .stk_data(stk_data), .rn(rn), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .busy(busy), .popped(popped)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  logic [7:0] stk_mem [8];
  int         sp = 0;
  assign empty = (sp == 0);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fill(input int n, input logic [63:0] bytes);
    sp = 0;
    for (int i = 0; i < n; i++) begin
      stk_mem[i] = bytes[8*i +: 8];
      sp++;
    end
  endtask

  task automatic stack_pop();
    if (sp > 0) begin
      sp--;
      stk_data = stk_mem[sp];
    end
  endtask

  // mode 0: ready always high, 1: first pending byte stalled 10 cycles, 2: random ready
  task automatic run_drain(input logic [CNT_W-1:0] cnt, input int mode, input string tag,
                           output int got_n);
    logic [8:0] exp_q[$];
    logic [8:0] got_q[$];
    logic [7:0] sum;
    int take, sp0, rn_cnt, viol, thr_viol, first_valid, last_hs, stall_left;
    logic prev_valid, prev_ready, prev_last;
    logic [7:0] prev_data;
    bit done;
    sp0  = sp;
    take = (cnt == 0 || int'(cnt) > sp) ? sp : int'(cnt);
    sum  = 8'h00;
    for (int k = 0; k < take; k++) begin
      sum = sum + stk_mem[sp - 1 - k];
      exp_q.push_back({(CS == 0) && (k == take - 1), stk_mem[sp - 1 - k]});
    end
    if (CS == 1) exp_q.push_back({1'b1, sum});
    rn_cnt = 0; viol = 0; thr_viol = 0; first_valid = -1; last_hs = -1;
    stall_left = (mode == 1) ? 10 : 0;
    prev_valid = 1'b0; prev_ready = 1'b0; prev_last = 1'b0; prev_data = '0;
    done = 0;
    @(negedge clock);
    start = 1'b1;
    count = cnt;
    for (int cyc = 1; cyc <= 400; cyc++) begin
      @(negedge clock);
      if (cyc == 1) start = 1'b0;
      if (rn) begin
        rn_cnt++;
        if (out_valid) viol++;
        stack_pop();
      end
      if (prev_valid && !prev_ready &&
          (!out_valid || out_data !== prev_data || out_last !== prev_last)) viol++;
      if (out_valid && first_valid < 0) first_valid = cyc;
      case (mode)
        0: out_ready = 1'b1;
        1: begin
          if (out_valid && stall_left > 0) begin
            out_ready = 1'b0;
            stall_left--;
          end else out_ready = 1'b1;
        end
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
      if (out_valid && out_ready) begin
        if (mode == 0 && got_q.size() > 0 && got_q.size() < take && cyc - last_hs != 4)
          thr_viol++;
        got_q.push_back({out_last, out_data});
        last_hs = cyc;
      end
      prev_valid = out_valid; prev_ready = out_ready;
      prev_data  = out_data;  prev_last  = out_last;
      if (cyc > 1 && !busy) begin
        done = 1;
        break;
      end
    end
    out_ready = 1'b0;
    if (!done) chk({tag, "/timeout"}, 0, 1);
    got_n = got_q.size();
    chk({tag, "/nbytes"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      chk($sformatf("%s/byte%0d", tag, i), {23'd0, got_q[i]}, {23'd0, exp_q[i]});
    chk({tag, "/popped"}, {28'd0, popped}, take);
    chk({tag, "/rn_pulses"}, rn_cnt, take);
    chk({tag, "/stack_left"}, sp, sp0 - take);
    chk({tag, "/protocol"}, viol, 0);
    if (mode == 0) chk({tag, "/throughput"}, thr_viol, 0);
    if (take > 0) chk({tag, "/latency"}, first_valid, 4);
  endtask

  typedef struct {
    int               n;
    logic [63:0]      bytes;
    logic [CNT_W-1:0] cnt;
    int               mode;
    int               exp_n;
    int               exp_popped;
    int               exp_left;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int got_n;
    int hs;
    bit ok;
    vecs[0] = '{3, 64'h0000_0000_0033_2211, 4'd0,  0, 3 + CS, 3, 0};
    vecs[1] = '{8, 64'h8877_6655_4433_2211, 4'd2,  0, 2 + CS, 2, 6};
    vecs[2] = '{0, 64'h0,                   4'd0,  0, 0 + CS, 0, 0};
    vecs[3] = '{4, 64'h0000_0000_4433_2211, 4'd0,  1, 4 + CS, 4, 0};
    vecs[4] = '{3, 64'h0000_0000_0003_FFFF, 4'd0,  0, 3 + CS, 3, 0};
    vecs[5] = '{5, 64'h0000_0055_4433_2211, 4'd12, 0, 5 + CS, 5, 0};
    vecs[6] = '{8, 64'h8877_6655_4433_2211, 4'd8,  0, 8 + CS, 8, 0};
    vecs[7] = '{6, 64'h0000_6655_4433_2211, 4'd3,  2, 3 + CS, 3, 3};

    reset = 1'b0; start = 1'b0; count = '0; out_ready = 1'b0; stk_data = '0; sp = 0;
    #12;
    chk("reset/rn", {31'd0, rn}, 0);
    chk("reset/out_data", {24'd0, out_data}, 0);
    chk("reset/out_valid", {31'd0, out_valid}, 0);
    chk("reset/out_last", {31'd0, out_last}, 0);
    chk("reset/busy", {31'd0, busy}, 0);
    chk("reset/popped", {28'd0, popped}, 0);
    @(negedge clock);
    reset = 1'b1;

    for (int v = 0; v < 8; v++) begin
      fill(vecs[v].n, vecs[v].bytes);
      run_drain(vecs[v].cnt, vecs[v].mode, $sformatf("vec%0d", v), got_n);
      chk($sformatf("vec%0d/tbl_n", v), got_n, vecs[v].exp_n);
      chk($sformatf("vec%0d/tbl_left", v), sp, vecs[v].exp_left);
      repeat (3) @(negedge clock);
      chk($sformatf("vec%0d/popped_hold", v), {28'd0, popped}, vecs[v].exp_popped);
      chk($sformatf("vec%0d/idle_busy", v), {31'd0, busy}, 0);
    end

    // Reset while the second byte is waiting for the consumer.
    fill(4, 64'h0000_0000_A4A3_A2A1);
    @(negedge clock);
    start = 1'b1; count = '0; out_ready = 1'b1; hs = 0; ok = 0;
    for (int cyc = 1; cyc <= 100; cyc++) begin
      @(negedge clock);
      if (cyc == 1) start = 1'b0;
      if (hs == 1) out_ready = 1'b0;
      if (rn) stack_pop();
      if (out_valid && hs == 1) begin
        #2 reset = 1'b0;
        #1;
        chk("abort/rn", {31'd0, rn}, 0);
        chk("abort/out_data", {24'd0, out_data}, 0);
        chk("abort/out_valid", {31'd0, out_valid}, 0);
        chk("abort/out_last", {31'd0, out_last}, 0);
        chk("abort/busy", {31'd0, busy}, 0);
        chk("abort/popped", {28'd0, popped}, 0);
        ok = 1;
        break;
      end
      if (out_valid && out_ready && hs == 0) begin
        chk("abort/first_byte", {24'd0, out_data}, 32'hA4);
        hs = 1;
      end
    end
    if (!ok) chk("abort/timeout", 0, 1);
    @(negedge clock);
    reset = 1'b1;
    chk("abort/stack_left", sp, 2);
    run_drain('0, 0, "restart", got_n);
    chk("restart/tbl_n", got_n, 2 + CS);

    for (int r = 0; r < 24; r++) begin
      int n;
      logic [63:0] b;
      n = $urandom_range(0, 8);
      b = {$urandom(), $urandom()};
      fill(n, b);
      run_drain(CNT_W'($urandom_range(0, 15)), r % 3, $sformatf("rnd%0d", r), got_n);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
